// File: rtl/drum_pkg.sv
// Shared fixed-point and row-indexing definitions for the drum column simulation
// and the sample collector.
package drum_pkg;

    localparam int FIX_W          = 18;
    localparam int ROW_W          = 5;
    localparam int NUM_ROWS_DEF   = 32;
    localparam int CENTER_ROW_DEF = 16;
    localparam int SAMPLE_W       = 32;
    localparam int SAMPLE_SHIFT   = SAMPLE_W - FIX_W;

    // Signed 1.16 node value u(n+1).
    typedef logic signed [FIX_W-1:0] node_t;

    function automatic logic [SAMPLE_W-1:0] format_sample(input node_t u);
        return {u, {SAMPLE_SHIFT{1'b0}}};
    endfunction

    // |u| with the most negative code clamped to the largest positive one.
    function automatic logic [FIX_W-1:0] abs_sat(input node_t u);
        logic [FIX_W-1:0] r;
        if (u == {1'b1, {(FIX_W-1){1'b0}}})
            r = {1'b0, {(FIX_W-1){1'b1}}};
        else if (u[FIX_W-1])
            r = -u;
        else
            r = u;
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is accepted only
// when a pop frees the head slot at the same edge.
module sample_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // When full, write and read slots coincide; the head is read before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/drum_sample_collector.sv
// Captures the centre-row node value of each column sweep as an audio sample,
// counts time steps and dropped samples. Optional SAMPLE_PEAK_DETECT_EN adds peak_out.
module drum_sample_collector
    import drum_pkg::*;
#(
    parameter int unsigned CENTER_ROW = CENTER_ROW_DEF,
    parameter int unsigned NUM_ROWS   = NUM_ROWS_DEF,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ROW_W-1:0]    row_in,
    input  logic [FIX_W-1:0]    u_np1_in,
    input  logic                u_valid_in,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [15:0]         step_cnt,
`ifdef SAMPLE_PEAK_DETECT_EN
    output logic [FIX_W-1:0]    peak_out,
`endif
    output logic [7:0]          overflow_cnt
);

    localparam logic [ROW_W-1:0] CENTER_IDX = ROW_W'(CENTER_ROW);
    localparam logic [ROW_W-1:0] LAST_IDX   = ROW_W'(NUM_ROWS - 1);

    logic                w_capture;
    logic                w_step;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [SAMPLE_W-1:0] w_head;
    logic [SAMPLE_W-1:0] r_hold;
    logic [15:0]         r_step_cnt;
    logic [7:0]          r_overflow_cnt;

    assign w_capture = u_valid_in && (row_in == CENTER_IDX);
    assign w_step    = u_valid_in && (row_in == LAST_IDX);

    // Output handshake: sample_valid means sample_data is the FIFO head; the head
    // leaves on a rising edge where sample_valid && sample_ready. ready is ignored when empty.
    assign sample_valid = !w_empty;
    assign w_pop        = sample_valid && sample_ready;
    assign w_drop       = w_capture && w_full && !w_pop;
    assign sample_data  = w_empty ? r_hold : w_head;
    assign step_cnt     = r_step_cnt;
    assign overflow_cnt = r_overflow_cnt;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_data  (format_sample(node_t'(u_np1_in))),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold         <= '0;
            r_step_cnt     <= '0;
            r_overflow_cnt <= '0;
        end else begin
            if (w_pop)  r_hold <= w_head;
            if (w_step) r_step_cnt <= r_step_cnt + 16'd1;
            if (w_drop && (r_overflow_cnt != 8'hFF))
                r_overflow_cnt <= r_overflow_cnt + 8'd1;
        end
    end

`ifdef SAMPLE_PEAK_DETECT_EN
    logic [FIX_W-1:0] w_abs;
    logic [FIX_W-1:0] r_peak;

    assign w_abs    = abs_sat(node_t'(u_np1_in));
    assign peak_out = r_peak;

    // A pop restarts the window; a capture at the same edge seeds it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_peak <= '0;
        end else if (w_pop) begin
            r_peak <= w_capture ? w_abs : '0;
        end else if (w_capture && (w_abs > r_peak)) begin
            r_peak <= w_abs;
        end
    end
`endif

endmodule
